// File: rtl/booth_radix4_multiplier_if.sv
// Request/result bundle for the radix-4 Booth multiplier.
// The master drives operands and start. The slave returns the product and status.
interface booth_radix4_multiplier_if #(
  parameter int unsigned WIDTH = 16
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] op;
  logic               busy;
  logic               read;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  op, busy, read
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output op, busy, read
  );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier that retires two multiplier bits per clock.
// Latency is fixed and independent of the data. Signed or unsigned mode is chosen per operation.
module booth_radix4_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     mrst,
  booth_radix4_multiplier_if.slave bus
);
  localparam int unsigned EW    = WIDTH + 2;
  localparam int unsigned NSTEP = EW / 2;
  localparam int unsigned AW    = EW + 1;
  localparam int unsigned TW    = AW + EW + 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [EW-1:0]   q_reg;
  logic [EW-1:0]   m_reg;
  logic            q_m1;
  logic [SW-1:0]   step;

  logic [AW-1:0]   m1_c;
  logic [AW-1:0]   m2_c;
  logic [AW-1:0]   addend_c;
  logic [AW-1:0]   sum_c;
  logic signed [TW-1:0] shifted_c;
  logic [AW-1:0]   acc_next_c;
  logic [EW-1:0]   q_next_c;
  logic            q_m1_next_c;
  logic [EW-1:0]   m_ext_c;
  logic [EW-1:0]   q_ext_c;

  // Operand extension: sign bits only in signed mode. The two extra bits keep the width even.
  always_comb begin
    m_ext_c = {{2{bus.signed_mode & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    q_ext_c = {{2{bus.signed_mode & bus.multiplier[WIDTH-1]}}, bus.multiplier};
  end

  // One Booth step: recode the triplet, add to A, then arithmetic-shift {A,Q,Q-1} right by two.
  always_comb begin
    m1_c     = {m_reg[EW-1], m_reg};
    m2_c     = {m_reg, 1'b0};
    addend_c = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend_c = m1_c;
      3'b011:         addend_c = m2_c;
      3'b100:         addend_c = AW'(0) - m2_c;
      3'b101, 3'b110: addend_c = AW'(0) - m1_c;
      default:        addend_c = '0;
    endcase
    sum_c     = acc + addend_c;
    shifted_c = $signed({sum_c, q_reg, q_m1}) >>> 2;
    {acc_next_c, q_next_c, q_m1_next_c} = shifted_c;
  end

  always_ff @(posedge clk_in) begin
    if (mrst) begin
      state    <= IDLE;
      acc      <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      q_m1     <= 1'b0;
      step     <= '0;
      bus.op   <= '0;
      bus.busy <= 1'b0;
      bus.read <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.read <= 1'b0;
          if (bus.start) begin
            state    <= RUN;
            acc      <= '0;
            q_reg    <= q_ext_c;
            m_reg    <= m_ext_c;
            q_m1     <= 1'b0;
            step     <= '0;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_next_c;
          q_reg <= q_next_c;
          q_m1  <= q_m1_next_c;
          step  <= step + SW'(1);
          // The last step commits the product straight from the adder output.
          if (step == SW'(NSTEP - 1)) begin
            state    <= DONE;
            bus.op   <= PW'({acc_next_c, q_next_c});
            bus.busy <= 1'b0;
            bus.read <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.read <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for the radix-4 Booth multiplier at WIDTH=16 and WIDTH=8.
// Expected products and latencies are worked out by hand.
module tb_booth_radix4_multiplier;
  logic clk = 1'b0;
  logic mrst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  booth_radix4_multiplier_if #(.WIDTH(16)) bus16 ();
  booth_radix4_multiplier_if #(.WIDTH(8))  bus8 ();

  booth_radix4_multiplier #(.WIDTH(16)) dut16 (.clk_in(clk), .mrst(mrst), .bus(bus16.slave));
  booth_radix4_multiplier #(.WIDTH(8))  dut8  (.clk_in(clk), .mrst(mrst), .bus(bus8.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run16(input logic sgn, input logic [15:0] m, input logic [15:0] q,
                       input logic [31:0] exp, input string tag);
    int n;
    int bc;
    @(negedge clk);
    bus16.start = 1'b1; bus16.signed_mode = sgn;
    bus16.multiplicand = m; bus16.multiplier = q;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.multiplicand = ~m; bus16.multiplier = ~q; bus16.signed_mode = ~sgn;
    n = 0; bc = 0;
    while (!bus16.read && n < 30) begin
      if (bus16.busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd9);
    check({tag, "_busy"}, 64'(bc), 64'd9);
    check({tag, "_op"}, 64'(bus16.op), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_rdpulse"}, 64'(bus16.read), 64'd0);
  endtask

  task automatic run8(input logic sgn, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp, input string tag);
    int n;
    int bc;
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = sgn;
    bus8.multiplicand = m; bus8.multiplier = q;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n = 0; bc = 0;
    while (!bus8.read && n < 30) begin
      if (bus8.busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd5);
    check({tag, "_busy"}, 64'(bc), 64'd5);
    check({tag, "_op"}, 64'(bus8.op), 64'(exp));
  endtask

  initial begin
    int n;
    int rd;
    mrst = 1'b1;
    bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.multiplicand = '0; bus16.multiplier = '0;
    bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.multiplicand  = '0; bus8.multiplier  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus16.busy), 64'd0);
    check("rst_read", 64'(bus16.read), 64'd0);
    check("rst_op", 64'(bus16.op), 64'd0);
    check("rst_op8", 64'(bus8.op), 64'd0);
    @(negedge clk);
    mrst = 1'b0;

    run16(1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, "s_m3x7");
    run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u_ffff");
    run16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "s_m1xm1");
    run16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "s_min_min");
    run16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "s_min_max");

    // A start while busy is dropped. A start in the DONE cycle chains without an idle cycle.
    @(negedge clk);
    bus16.start = 1'b1; bus16.signed_mode = 1'b1;
    bus16.multiplicand = 16'd3; bus16.multiplier = 16'd5;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b1; bus16.multiplicand = 16'd9; bus16.multiplier = 16'd9;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    n = 3;
    while (!bus16.read && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_lat1", 64'(n), 64'd9);
    check("b2b_op1", 64'(bus16.op), 64'h0000000F);
    bus16.start = 1'b1; bus16.signed_mode = 1'b0;
    bus16.multiplicand = 16'h1234; bus16.multiplier = 16'h0010;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    check("b2b_rd_off", 64'(bus16.read), 64'd0);
    check("b2b_nogap", 64'(bus16.busy), 64'd1);
    check("b2b_hold", 64'(bus16.op), 64'h0000000F);
    n = 0;
    while (!bus16.read && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_lat2", 64'(n), 64'd9);
    check("b2b_op2", 64'(bus16.op), 64'h00012340);

    // Reset in the middle of an operation aborts it. No read pulse follows.
    @(negedge clk);
    bus16.start = 1'b1; bus16.signed_mode = 1'b0;
    bus16.multiplicand = 16'd100; bus16.multiplier = 16'd100;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    mrst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(bus16.busy), 64'd0);
    check("abort_op", 64'(bus16.op), 64'd0);
    check("abort_read", 64'(bus16.read), 64'd0);
    mrst = 1'b0;
    rd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus16.read) rd++;
    end
    check("abort_noread", 64'(rd), 64'd0);
    run16(1'b1, 16'd2, 16'd3, 32'd6, "post_abort");

    run8(1'b1, 8'h80, 8'h80, 16'h4000, "w8_min_min");
    run8(1'b1, 8'h7F, 8'h80, 16'hC080, "w8_max_min");
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_u_ff");
    run8(1'b0, 8'hAB, 8'h02, 16'h0156, "w8_u_ab2");
    run8(1'b1, 8'hFE, 8'h05, 16'hFFF6, "w8_s_m2x5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
